// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// Op encodings, FSM states and iteration constants.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_NONE  = 3'd0,
        MDU_MULT  = 3'd1,
        MDU_MULTU = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } mdu_state_e;

    localparam int DIV_ITER = 32;
    localparam int CNT_W    = 6;

    // Magnitude of a value that is signed only when s is set.
    function automatic logic [31:0] abs32(
        input logic [31:0] v,
        input logic        s
    );
        return (s && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider, one quotient bit per step.
// Operands are unsigned magnitudes; sign handling lives in the caller.
import mdu_pkg::*;

module mdu_div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_start,
    input  logic        i_step,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem,
    output logic        o_done
);

    logic [31:0]      r_rem;
    logic [31:0]      r_quo;
    logic [31:0]      r_dvs;
    logic [CNT_W-1:0] r_cnt;
    logic [32:0]      w_part;
    logic [32:0]      w_trial;

    assign w_part  = {r_rem, r_quo[31]};
    assign w_trial = w_part - {1'b0, r_dvs};

    // Load operands on start, then shift one dividend bit per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_quo <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= '0;
            r_quo <= i_dividend;
            r_dvs <= i_divisor;
            r_cnt <= '0;
        end else if (i_step) begin
            if (!w_trial[32]) begin
                r_rem <= w_trial[31:0];
                r_quo <= {r_quo[30:0], 1'b1};
            end else begin
                r_rem <= w_part[31:0];
                r_quo <= {r_quo[30:0], 1'b0};
            end
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_quot = r_quo;
    assign o_rem  = r_rem;
    assign o_done = (r_cnt == CNT_W'(DIV_ITER));

endmodule

// File: rtl/mdu_unit.sv
// EX-stage multiply/divide unit owning HI/LO.
// Holds the pipeline via MDUReadyE while an op is in flight.
import mdu_pkg::*;

module mdu_unit #(
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [2:0]  MDUOpE,
    input  logic [31:0] SrcAE,
    input  logic [31:0] SrcBE,
    input  logic        MDUFlushE,
    output logic        MDUReadyE,
    output logic [31:0] HiE,
    output logic [31:0] LoE
);

    mdu_state_e       r_state;
    mdu_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_op;
    logic [31:0]      r_a;
    logic [31:0]      r_b;
    logic [63:0]      r_prod;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;

    logic        w_is_mul;
    logic        w_is_div;
    logic        w_start;
    logic        w_ready;
    logic        w_sdiv_in;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_msg;
    logic [63:0] w_ma;
    logic [63:0] w_mb;
    logic [63:0] w_mp;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_div_done;
    logic        w_dz;
    logic        w_qneg;
    logic        w_rneg;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_res_ok;
    logic        w_r_mul;

    // Decode the incoming EX op into multiply/divide classes.
    always_comb begin
        w_is_mul = 1'b0;
        w_is_div = 1'b0;
        unique case (1'b1)
            (MDUOpE == MDU_MULT),
            (MDUOpE == MDU_MULTU): w_is_mul = 1'b1;
            (MDUOpE == MDU_DIV),
            (MDUOpE == MDU_DIVU):  w_is_div = 1'b1;
            default: ;
        endcase
    end

    assign w_start   = (r_state == S_IDLE) && !MDUFlushE
                     && (w_is_mul || w_is_div);
    assign w_sdiv_in = (MDUOpE == MDU_DIV);
    assign w_abs_a   = abs32(SrcAE, w_sdiv_in);
    assign w_abs_b   = abs32(SrcBE, w_sdiv_in);

    // Next state and the pipeline hold signal.
    always_comb begin
        w_next  = r_state;
        w_ready = 1'b1;
        if (MDUFlushE) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_mul || w_is_div) begin
                        w_ready = 1'b0;
                        w_next  = S_BUSY;
                    end
                end
                S_BUSY: begin
                    w_ready = 1'b0;
                    if (r_cnt == CNT_W'(1)) w_next = S_DONE;
                end
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    assign MDUReadyE = w_ready;

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Latch operands and time the operation with a down-counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
            r_op  <= MDU_NONE;
            r_a   <= '0;
            r_b   <= '0;
        end else if (MDUFlushE) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= w_is_mul ? CNT_W'(MULT_LAT) : CNT_W'(DIV_ITER);
            r_op  <= MDUOpE;
            r_a   <= SrcAE;
            r_b   <= SrcBE;
        end else if (r_state == S_BUSY) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // One 64-bit multiplier; sign extension selects MULT vs MULTU.
    assign w_msg = (r_op == MDU_MULT);
    assign w_ma  = {{32{w_msg & r_a[31]}}, r_a};
    assign w_mb  = {{32{w_msg & r_b[31]}}, r_b};
    assign w_mp  = w_ma * w_mb;

    // Register the product while busy; held until DONE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                 r_prod <= '0;
        else if (r_state == S_BUSY)  r_prod <= w_mp;
    end

    mdu_div_iter u_div (
        .clk        (clk),
        .rst_n      (resetn),
        .i_start    (w_start && w_is_div),
        .i_step     (r_state == S_BUSY),
        .i_dividend (w_abs_a),
        .i_divisor  (w_abs_b),
        .o_quot     (w_quot),
        .o_rem      (w_rem),
        .o_done     (w_div_done)
    );

    assign w_r_mul = (r_op == MDU_MULT) || (r_op == MDU_MULTU);
    assign w_dz    = (r_b == 32'd0);
    assign w_qneg  = (r_op == MDU_DIV) && (r_a[31] ^ r_b[31]);
    assign w_rneg  = (r_op == MDU_DIV) && r_a[31];

    // Final HI/LO value; divide-by-zero bypasses the sign fix.
    always_comb begin
        w_res_hi = r_prod[63:32];
        w_res_lo = r_prod[31:0];
        if (!w_r_mul) begin
            if (w_dz) begin
                w_res_hi = r_a;
                w_res_lo = 32'hFFFF_FFFF;
            end else begin
                w_res_hi = w_rneg ? (32'd0 - w_rem)  : w_rem;
                w_res_lo = w_qneg ? (32'd0 - w_quot) : w_quot;
            end
        end
    end

    assign w_res_ok = w_r_mul || w_div_done;

    // HI/LO update from a finished op or MTHI/MTLO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (!MDUFlushE) begin
            if (r_state == S_DONE && w_res_ok) begin
                r_hi <= w_res_hi;
                r_lo <= w_res_lo;
            end else if (r_state == S_IDLE) begin
                if (MDUOpE == MDU_MTHI) r_hi <= SrcAE;
                if (MDUOpE == MDU_MTLO) r_lo <= SrcAE;
            end
        end
    end

    assign HiE = r_hi;
    assign LoE = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed-vector bench for mdu_unit.
// Expected values are hand-computed constants.
`timescale 1ns/1ps
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [2:0]  MDUOpE = 3'd0;
    logic [31:0] SrcAE = '0;
    logic [31:0] SrcBE = '0;
    logic        MDUFlushE = 1'b0;
    logic        MDUReadyE;
    logic [31:0] HiE;
    logic [31:0] LoE;

    int n_vec = 0;
    int n_err = 0;
    int lows;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;

    mdu_unit #(.MULT_LAT(3)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .MDUOpE    (MDUOpE),
        .SrcAE     (SrcAE),
        .SrcBE     (SrcBE),
        .MDUFlushE (MDUFlushE),
        .MDUReadyE (MDUReadyE),
        .HiE       (HiE),
        .LoE       (LoE)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present an op as the EX instruction, hold it while stalled,
    // retire it on the first ready cycle's edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int n_low);
        MDUOpE = op;
        SrcAE  = a;
        SrcBE  = b;
        n_low  = 0;
        forever begin
            @(negedge clk);
            if (MDUReadyE) break;
            n_low++;
            if (n_low > 100) break;
        end
        @(posedge clk);
        #1;
        MDUOpE = OP_NONE;
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(MDUReadyE), 32'd1);
        chk("rst_hi", HiE, 32'd0);
        chk("rst_lo", LoE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_MULT, 32'hFFFF_FFFE, 32'h0000_0003, lows);
        chk("mult_lows", 32'(lows), 32'd4);
        chk("mult_hi", HiE, 32'hFFFF_FFFF);
        chk("mult_lo", LoE, 32'hFFFF_FFFA);

        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lows);
        chk("multu_lows", 32'(lows), 32'd4);
        chk("multu_hi", HiE, 32'hFFFF_FFFE);
        chk("multu_lo", LoE, 32'h0000_0001);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, lows);
        chk("div_lows", 32'(lows), 32'd33);
        chk("div_lo", LoE, 32'hFFFF_FFFD);
        chk("div_hi", HiE, 32'hFFFF_FFFF);

        issue(OP_DIVU, 32'd100, 32'd0, lows);
        chk("divu0_lo", LoE, 32'hFFFF_FFFF);
        chk("divu0_hi", HiE, 32'd100);

        issue(OP_DIV, 32'hFFFF_FFF9, 32'd0, lows);
        chk("div0_lo", LoE, 32'hFFFF_FFFF);
        chk("div0_hi", HiE, 32'hFFFF_FFF9);

        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lows);
        chk("divovf_lo", LoE, 32'h8000_0000);
        chk("divovf_hi", HiE, 32'd0);

        issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16, lows);
        chk("divu_lo", LoE, 32'h0FFF_FFFF);
        chk("divu_hi", HiE, 32'd15);

        issue(OP_MULT, 32'd5, 32'd6, lows);
        chk("b2b_mul_lows", 32'(lows), 32'd4);
        chk("b2b_mul_lo", LoE, 32'd30);
        chk("b2b_mul_hi", HiE, 32'd0);
        issue(OP_DIV, 32'd100, 32'd7, lows);
        chk("b2b_div_lows", 32'(lows), 32'd33);
        chk("b2b_div_lo", LoE, 32'd14);
        chk("b2b_div_hi", HiE, 32'd2);
        issue(OP_MTHI, 32'h0000_1234, 32'd0, lows);
        chk("mthi_lows", 32'(lows), 32'd0);
        chk("mthi_hi", HiE, 32'h0000_1234);
        chk("mthi_lo", LoE, 32'd14);

        // Flush at BUSY cycle 10 of a divide.
        MDUOpE = OP_DIV;
        SrcAE  = 32'd1000;
        SrcBE  = 32'd3;
        @(posedge clk);
        #1;
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        MDUFlushE = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(MDUReadyE), 32'd1);
        @(posedge clk);
        #1;
        MDUFlushE = 1'b0;
        MDUOpE    = OP_NONE;
        @(negedge clk);
        chk("flush_idle", 32'(MDUReadyE), 32'd1);
        chk("flush_hi", HiE, 32'h0000_1234);
        chk("flush_lo", LoE, 32'd14);

        // Flush in IDLE with a valid op suppresses the start.
        @(posedge clk);
        #1;
        MDUOpE    = OP_MULT;
        MDUFlushE = 1'b1;
        @(negedge clk);
        chk("iflush_ready", 32'(MDUReadyE), 32'd1);
        @(posedge clk);
        #1;
        MDUOpE    = OP_NONE;
        MDUFlushE = 1'b0;
        @(negedge clk);
        chk("iflush_idle", 32'(MDUReadyE), 32'd1);
        chk("iflush_lo", LoE, 32'd14);

        // Reset pulse in the middle of a multiply.
        @(posedge clk);
        #1;
        MDUOpE = OP_MULT;
        SrcAE  = 32'd3;
        SrcBE  = 32'd3;
        @(posedge clk);
        #1;
        MDUOpE = OP_NONE;
        #2;
        resetn = 1'b0;
        #1;
        chk("mrst_ready", 32'(MDUReadyE), 32'd1);
        chk("mrst_hi", HiE, 32'd0);
        chk("mrst_lo", LoE, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_MULTU, 32'd2, 32'd3, lows);
        chk("post_lows", 32'(lows), 32'd4);
        chk("post_lo", LoE, 32'd6);
        chk("post_hi", HiE, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
